// File: rtl/clock_edge_monitor.sv
// -----------------------------------------------------------------------------
// clock_edge_monitor
//
// Receive-side companion to the clock dividers. Brings a slow clock that is
// asynchronous to clk into the clk domain and emits one-cycle rise/fall
// enables. It also measures the rise-to-rise period in clk cycles and asserts
// locked once that period has been stable for LOCK_COUNT consecutive
// measurements.
//
// Optional feature macro: CLOCK_EDGE_MONITOR_DUTY_EN
//   defined   : high_time reports the length of the last high phase of clk_in
//   undefined : high_time is tied to 0 and no high-phase counter is built
//
// Parameters
//   SYNC_STAGES  synchronizer depth on clk_in (2..4)
//   PERIOD_W     width of the period counter and of period/high_time
//   LOCK_COUNT   consecutive in-tolerance periods needed for lock (>=1)
//   TOL          largest |new - previous| period still counted as a match
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   clk_in       in   monitored slow clock (asynchronous to clk)
//   rise_en      out  1-cycle pulse per synchronized rising edge of clk_in
//   fall_en      out  1-cycle pulse per synchronized falling edge of clk_in
//   period       out  last measured rise-to-rise interval in clk cycles
//   period_valid out  period holds a real measurement
//   locked       out  period stable for LOCK_COUNT measurements
//   timeout      out  1-cycle pulse when the period counter saturates
//   high_time    out  clk cycles clk_in was high in its last high phase
//
// The FSM state register (state_q) is a plain enum so checkers can bind to it.
// -----------------------------------------------------------------------------
module clock_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_in,
  output logic                rise_en,
  output logic                fall_en,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                timeout,
  output logic [PERIOD_W-1:0] high_time
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W:0]   TOL_W   = (PERIOD_W + 1)'(TOL);
  localparam int                  MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]     MC_MAX  = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]     MC_ONE  = MC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no edge seen since reset or timeout
    ST_ACQ  = 2'd1,  // measuring, not yet stable
    ST_LOCK = 2'd2   // period stable
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      rise_en <= 1'b0;
      fall_en <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d_q   <= s;
      rise_en <= rise;
      fall_en <= fall;
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter. A rise loads 1, so the count seen at the next rise equals
  // the rise-to-rise distance. timed_out_q makes the saturation event fire
  // once per saturation rather than every cycle the counter sits at max.
  // ---------------------------------------------------------------------------
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                timed_out_q, timed_out_d;
  logic                sat;

  assign sat = (cnt_q == CNT_MAX) && !timed_out_q;

  always_comb begin
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    if (rise) begin
      cnt_d       = CNT_ONE;
      timed_out_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      if (sat) timed_out_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [MC_W-1:0]     match_q, match_d;
  logic                first_q, first_d;
  logic [PERIOD_W-1:0] period_d;
  logic                valid_d;
  logic                locked_d;
  logic                timeout_d;
  logic [PERIOD_W:0]   cnt_x, per_x, diff;

  // Extra bit so the difference can never wrap.
  assign cnt_x = {1'b0, cnt_q};
  assign per_x = {1'b0, period};
  assign diff  = (cnt_x >= per_x) ? (cnt_x - per_x) : (per_x - cnt_x);

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    first_d   = first_q;
    period_d  = period;
    valid_d   = period_valid;
    timeout_d = 1'b0;

    if (rise) begin
      if (state_q == ST_IDLE) begin
        // First edge only starts the counter; nothing to measure yet.
        state_d = ST_ACQ;
        match_d = '0;
        first_d = 1'b1;
      end else if (sat) begin
        // Rise coincides with saturation: the interval is not trustworthy,
        // so restart acquisition without capturing and without a timeout.
        state_d = ST_ACQ;
        match_d = '0;
        first_d = 1'b1;
        valid_d = 1'b0;
      end else begin
        period_d = cnt_q;
        valid_d  = 1'b1;
        if (first_q) begin
          first_d = 1'b0;
        end else if (diff <= TOL_W) begin
          if (match_q != MC_MAX) match_d = match_q + MC_ONE;
          if (match_d == MC_MAX) state_d = ST_LOCK;
        end else begin
          match_d = '0;
          state_d = ST_ACQ;
        end
      end
    end else if (sat) begin
      timeout_d = 1'b1;
      state_d   = ST_IDLE;
      match_d   = '0;
      valid_d   = 1'b0;
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      timed_out_q  <= 1'b0;
      state_q      <= ST_IDLE;
      match_q      <= '0;
      first_q      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      timed_out_q  <= timed_out_d;
      state_q      <= state_d;
      match_q      <= match_d;
      first_q      <= first_d;
      period       <= period_d;
      period_valid <= valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional high-phase measurement
  // ---------------------------------------------------------------------------
`ifdef CLOCK_EDGE_MONITOR_DUTY_EN
  logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
  logic [PERIOD_W-1:0] high_time_q, high_time_d;

  always_comb begin
    hcnt_d      = hcnt_q;
    high_time_d = high_time_q;
    if (rise) begin
      hcnt_d = CNT_ONE;
    end else if (s && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
    if (fall) high_time_d = hcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      high_time_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  assign high_time = '0;
`endif

endmodule
